basic_axis_lane_adder: RTL and testbench

//  Kernel-clock AXI4-Stream processing stage: sits after the AXI read master stream and before the write master stream.

---
 rtl/basic_axis_pkg.sv | 25 ++
 rtl/basic_axis_skid_buffer.sv | 41 ++++
 rtl/basic_axis_lane_adder.sv | 107 ++++++++++
 tb/tb_basic_axis_lane_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/basic_axis_pkg.sv
// basic_axis_pkg: shared state enum, lane-width defaults and the lane adder (BASIC_AXIS_LANE_SATURATE_EN selects saturate vs wrap)
package basic_axis_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} lane_adder_state_t;

    localparam int LP_LANE_W_DEFAULT = 32;
    localparam int LP_LANE_W_MAX     = 64;

    // Operands arrive zero-extended to LP_LANE_W_MAX; w is the real lane width, so bit w of the sum is the lane carry-out.
    function automatic logic [LP_LANE_W_MAX-1:0] lane_add(
        input logic [LP_LANE_W_MAX-1:0] a,
        input logic [LP_LANE_W_MAX-1:0] b,
        input int                       w
    );
        logic [LP_LANE_W_MAX:0] one, mask, sum;
        one  = {{LP_LANE_W_MAX{1'b0}}, 1'b1};
        mask = (one << w) - one;
        sum  = {1'b0, a} + {1'b0, b};
`ifdef BASIC_AXIS_LANE_SATURATE_EN
        if (|(sum >> w)) sum = mask;
`endif
        return sum[LP_LANE_W_MAX-1:0] & mask[LP_LANE_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/basic_axis_skid_buffer.sv
// basic_axis_skid_buffer: 2-entry valid/ready register slice with registered outputs
module basic_axis_skid_buffer
#(
    parameter int W = 1
)
(
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] out_q, spare_q;
    logic         out_v_q, spare_v_q;

    assign in_ready_o  = !spare_v_q;
    assign out_valid_o = out_v_q;
    assign out_data_o  = out_q;

    // Output register refills from the spare entry first; the spare only catches a beat while the output is stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_q     <= '0;
            out_v_q   <= 1'b0;
            spare_q   <= '0;
            spare_v_q <= 1'b0;
        end else if (!out_v_q || out_ready_i) begin
            out_v_q   <= spare_v_q || in_valid_i;
            if (spare_v_q || in_valid_i) out_q <= spare_v_q ? spare_q : in_data_i;
            spare_v_q <= 1'b0;
        end else if (in_valid_i && !spare_v_q) begin
            spare_q   <= in_data_i;
            spare_v_q <= 1'b1;
        end
    end

endmodule

// File: rtl/basic_axis_lane_adder.sv
// basic_axis_lane_adder: per-lane constant adder between AXI4-Stream read and write masters (saturation under BASIC_AXIS_LANE_SATURATE_EN)
module basic_axis_lane_adder
    import basic_axis_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_W           = LP_LANE_W_DEFAULT,
    parameter int C_XFER_SIZE_WIDTH  = 32
)
(
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          ctrl_start,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_num_beats,
    input  logic [C_LANE_W-1:0]           ctrl_constant,
    output logic                          ctrl_busy,
    output logic                          ctrl_done,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast
);

    localparam int LP_LANES = C_AXIS_TDATA_WIDTH / C_LANE_W;
    localparam logic [C_XFER_SIZE_WIDTH-1:0] LP_ONE = {{(C_XFER_SIZE_WIDTH-1){1'b0}}, 1'b1};

    lane_adder_state_t               state_q, state_d;
    logic [C_XFER_SIZE_WIDTH-1:0]    num_q, in_cnt_q, out_cnt_q, out_cnt_d;
    logic [C_LANE_W-1:0]             const_q;
    logic [C_AXIS_TDATA_WIDTH-1:0]   sum_d, stage_data_q;
    logic                            stage_valid_q, stage_last_q;
    logic                            skid_ready, s_hs, m_hs;

    assign s_axis_tready = (state_q == RUN) && (in_cnt_q < num_q) && (!stage_valid_q || skid_ready);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign out_cnt_d     = m_hs ? out_cnt_q + LP_ONE : out_cnt_q;
    assign ctrl_busy     = state_q != IDLE;
    assign ctrl_done     = state_q == DONE;

    for (genvar g = 0; g < LP_LANES; g++) begin : g_lane
        assign sum_d[g*C_LANE_W +: C_LANE_W] = C_LANE_W'(lane_add(LP_LANE_W_MAX'(s_axis_tdata[g*C_LANE_W +: C_LANE_W]),
                                                                  LP_LANE_W_MAX'(const_q), C_LANE_W));
    end

    // Job control: latch the job at an accepted start, count accepted and delivered beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            num_q     <= '0;
            const_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ctrl_start) begin
                num_q     <= ctrl_num_beats;
                const_q   <= ctrl_constant;
                in_cnt_q  <= '0;
                out_cnt_q <= '0;
            end else begin
                if (s_hs) in_cnt_q <= in_cnt_q + LP_ONE;
                out_cnt_q <= out_cnt_d;
            end
        end
    end

    // Next state: FLUSH exits in the same cycle the final beat is delivered so done follows it by one clock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctrl_start) state_d = (ctrl_num_beats == '0) ? DONE : RUN;
            RUN:     if (in_cnt_q == num_q) state_d = FLUSH;
            FLUSH:   if (out_cnt_d == num_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Add stage: holds its result until the skid buffer takes it; tlast is decided here by input index.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_last_q  <= 1'b0;
        end else if (!stage_valid_q || skid_ready) begin
            stage_valid_q <= s_hs;
            if (s_hs) begin
                stage_data_q <= sum_d;
                stage_last_q <= (in_cnt_q + LP_ONE) == num_q;
            end
        end
    end

    basic_axis_skid_buffer #(.W(C_AXIS_TDATA_WIDTH + 1)) u_skid (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_valid_i  (stage_valid_q),
        .in_ready_o  (skid_ready),
        .in_data_i   ({stage_last_q, stage_data_q}),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .out_data_o  ({m_axis_tlast, m_axis_tdata})
    );

endmodule

// File: tb/tb_basic_axis_lane_adder.sv
// tb_basic_axis_lane_adder: directed vector table plus scoreboarded job sequences for basic_axis_lane_adder
module tb_basic_axis_lane_adder;

    localparam int TW = 512;
    localparam int NL = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          ctrl_start = 1'b0;
    logic [31:0]   ctrl_num_beats = '0;
    logic [31:0]   ctrl_constant = '0;
    logic          ctrl_busy, ctrl_done;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [TW-1:0] s_axis_tdata = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [TW-1:0] m_axis_tdata;
    logic          m_axis_tlast;

    int n_cmp = 0;
    int n_bad = 0;
    logic [TW-1:0] first_out, last_out;
    logic [TW-1:0] exp_d[$];
    logic          exp_l[$];

    always #5 aclk = ~aclk;

    basic_axis_lane_adder dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .ctrl_start     (ctrl_start),
        .ctrl_num_beats (ctrl_num_beats),
        .ctrl_constant  (ctrl_constant),
        .ctrl_busy      (ctrl_busy),
        .ctrl_done      (ctrl_done),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast)
    );

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef BASIC_AXIS_LANE_SATURATE_EN
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
        return s[31:0];
`endif
    endfunction

    function automatic logic [TW-1:0] m_beat(input logic [TW-1:0] d, input logic [31:0] c);
        logic [TW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*32 +: 32] = m_add(d[i*32 +: 32], c);
        return r;
    endfunction

    function automatic logic [TW-1:0] mk(input int k, input logic [31:0] base);
        logic [TW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*32 +: 32] = base + 32'(k * NL + i);
        return r;
    endfunction

    task automatic run(input string tag, input int nb, input logic [31:0] c, input int offer,
                       input int rdy_pct, input int rst_after, input bit restart, input logic [31:0] base);
        int acc = 0, sent = 0, outs = 0, done_n = 0, busy_n = 0;
        int done_cyc = -1, last_hs = -1, first_s = -1, first_m = -1;
        bit prev_stall = 0, ended = 0;
        logic [TW-1:0] prev_d = '0;
        logic prev_l = 1'b0;
        exp_d.delete();
        exp_l.delete();
        for (int cyc = 0; cyc < 2000 && !ended; cyc++) begin
            @(posedge aclk);
            #1;
            ctrl_start     = (cyc == 0) || (restart && acc == nb && done_n == 0);
            ctrl_num_beats = (cyc == 0) ? 32'(nb) : 32'd5;
            ctrl_constant  = (cyc == 0) ? c : 32'h0BAD_0BAD;
            s_axis_tvalid  = sent < offer;
            s_axis_tdata   = mk(sent, base);
            m_axis_tready  = $urandom_range(99) < rdy_pct;
            #1;
            if (ctrl_busy) busy_n++;
            if (s_axis_tvalid && s_axis_tready) begin
                chk({tag, "_accept_within_count"}, 512'(acc < nb), 512'd1);
                if (first_s < 0) first_s = cyc;
                exp_d.push_back(m_beat(s_axis_tdata, c));
                exp_l.push_back(acc == nb - 1);
                acc++;
                sent++;
            end
            if (m_axis_tvalid && first_m < 0) first_m = cyc;
            if (prev_stall) begin
                chk({tag, "_stall_valid"}, 512'(m_axis_tvalid), 512'd1);
                chk({tag, "_stall_data"}, m_axis_tdata, prev_d);
                chk({tag, "_stall_last"}, 512'(m_axis_tlast), 512'(prev_l));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                chk({tag, "_beat_expected"}, 512'(exp_d.size() != 0), 512'd1);
                if (exp_d.size() != 0) begin
                    chk({tag, "_data"}, m_axis_tdata, exp_d.pop_front());
                    chk({tag, "_last"}, 512'(m_axis_tlast), 512'(exp_l.pop_front()));
                end
                if (outs == 0) first_out = m_axis_tdata;
                last_out = m_axis_tdata;
                outs++;
                last_hs = cyc;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d     = m_axis_tdata;
            prev_l     = m_axis_tlast;
            if (ctrl_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (rst_after > 0 && acc == rst_after) begin
                aresetn = 1'b0;
                #1;
                chk({tag, "_rst_m_tvalid"}, 512'(m_axis_tvalid), 512'd0);
                chk({tag, "_rst_s_tready"}, 512'(s_axis_tready), 512'd0);
                chk({tag, "_rst_busy"}, 512'(ctrl_busy), 512'd0);
                chk({tag, "_rst_tdata"}, m_axis_tdata, 512'd0);
                ctrl_start    = 1'b0;
                s_axis_tvalid = 1'b0;
                @(posedge aclk);
                #1;
                aresetn = 1'b1;
                return;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) ended = 1;
        end
        ctrl_start    = 1'b0;
        s_axis_tvalid = 1'b0;
        chk({tag, "_done_pulses"}, 512'(done_n), 512'd1);
        chk({tag, "_out_count"}, 512'(outs), 512'(nb));
        chk({tag, "_acc_count"}, 512'(acc), 512'(nb));
        chk({tag, "_busy_cycles"}, 512'(busy_n), 512'(done_cyc));
        if (nb == 0) chk({tag, "_done_cycle"}, 512'(done_cyc), 512'd1);
        else chk({tag, "_done_after_last"}, 512'(done_cyc), 512'(last_hs + 1));
        if (rdy_pct == 100 && nb > 0) begin
            chk({tag, "_latency"}, 512'(first_m), 512'(first_s + 2));
            chk({tag, "_full_rate_done"}, 512'(done_cyc), 512'(nb + 3));
        end
    endtask

    typedef struct {
        logic [31:0] lane;
        logic [31:0] c;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFF};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        tbl[3] = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[4] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'h2345_6789};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};

        repeat (2) @(posedge aclk);
        #1;
        chk("reset_s_tready", 512'(s_axis_tready), 512'd0);
        chk("reset_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        chk("reset_m_tlast", 512'(m_axis_tlast), 512'd0);
        chk("reset_m_tdata", m_axis_tdata, 512'd0);
        chk("reset_busy", 512'(ctrl_busy), 512'd0);
        chk("reset_done", 512'(ctrl_done), 512'd0);
        aresetn = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run($sformatf("vec%0d", v), 1, tbl[v].c, 1, 100, 0, 0, tbl[v].lane);
`ifdef BASIC_AXIS_LANE_SATURATE_EN
            chk($sformatf("vec%0d_lane0", v), 512'(last_out[31:0]), 512'(tbl[v].exp_sat));
`else
            chk($sformatf("vec%0d_lane0", v), 512'(last_out[31:0]), 512'(tbl[v].exp_wrap));
`endif
        end

        run("t1", 4, 32'd1, 4, 100, 0, 0, 32'd0);
        chk("t1_lane0", 512'(first_out[31:0]), 512'd1);
        chk("t1_lane15", 512'(first_out[511:480]), 512'd16);

        run("t3", 64, 32'h0100_0003, 64, 50, 0, 0, 32'h0000_1000);
        run("t4", 0, 32'd5, 3, 100, 0, 0, 32'd0);
        run("t5", 8, 32'd7, 8, 100, 3, 0, 32'd0);
        run("t5b", 2, 32'd9, 2, 100, 0, 0, 32'h0000_0040);
        run("t6", 2, 32'd3, 5, 30, 0, 1, 32'h0000_0200);
        run("t7", 3, 32'hFFFF_FFF0, 3, 100, 0, 0, 32'h0000_0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
